// File: rtl/alu_sequencer_pkg.sv
// Shared types for the ALU sequencer: opcodes, ALU control word, FSM states.
package alu_sequencer_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_ROT = 4'd5,
    OP_ADC = 4'd6,
    OP_MUL = 4'd7
  } op_e;

  typedef struct packed {
    logic ci;
    logic nb;
    logic ic;
    logic na;
    logic xo;
    logic no;
    logic rot;
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    MUL_LOOP,
    RESP
  } state_e;

  localparam int MUL_ITERS = 16;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode to ALU control-word decode; opcodes 8-15 flag illegal.
module alu_op_decode
  import alu_sequencer_pkg::*;
(
  input  logic [3:0] op,
  input  logic       carry,
  output alu_ctrl_t  ctrl,
  output logic       illegal
);

  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    case (op)
      OP_ADD: ;
      OP_SUB: begin ctrl.ci = 1'b1; ctrl.nb = 1'b1; end
      // AND built as NOT(~a | ~b)
      OP_AND: begin
        ctrl.na = 1'b1; ctrl.nb = 1'b1; ctrl.ic = 1'b1;
        ctrl.xo = 1'b1; ctrl.no = 1'b1;
      end
      OP_OR:  begin ctrl.ic = 1'b1; ctrl.xo = 1'b1; end
      OP_XOR: ctrl.ic  = 1'b1;
      OP_ROT: ctrl.rot = 1'b1;
      OP_ADC: ctrl.ci  = carry;
      OP_MUL: ;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Command/response sequencer driving an external combinational ALU;
// MUL is run as a 16-step shift-add through the ALU adder.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [3:0]   cmd_op,
  input  logic [W-1:0] cmd_a,
  input  logic [W-1:0] cmd_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_data,
  output logic         rsp_cf,
  output logic         rsp_zf,
  output logic         rsp_err,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic         alu_ci,
  output logic         alu_nb,
  output logic         alu_ic,
  output logic         alu_na,
  output logic         alu_xo,
  output logic         alu_no,
  output logic         alu_rot,
  input  logic [W-1:0] alu_o,
  input  logic         alu_cf,
  input  logic         alu_zf
);

  state_e       state;
  logic [3:0]   op_r;
  logic [W-1:0] a_r, b_r, acc;
  logic [3:0]   cnt;
  logic         flag_cf, flag_zf;
  alu_ctrl_t    dec_ctrl, ctrl;
  logic         dec_ill;
  logic [W-1:0] mul_next;

  alu_op_decode u_dec (
    .op      (op_r),
    .carry   (flag_cf),
    .ctrl    (dec_ctrl),
    .illegal (dec_ill)
  );

  assign cmd_ready = (state == IDLE);
  assign mul_next  = b_r[cnt] ? alu_o : acc;

  always_comb begin
    alu_a = '0;
    alu_b = '0;
    ctrl  = '0;
    case (state)
      EXEC:     begin alu_a = a_r; alu_b = b_r; ctrl = dec_ctrl; end
      MUL_LOOP: begin alu_a = acc; alu_b = a_r; end
      default: ;
    endcase
  end

  assign alu_ci  = ctrl.ci;
  assign alu_nb  = ctrl.nb;
  assign alu_ic  = ctrl.ic;
  assign alu_na  = ctrl.na;
  assign alu_xo  = ctrl.xo;
  assign alu_no  = ctrl.no;
  assign alu_rot = ctrl.rot;

  // a_r doubles as the shifting multiplicand during MUL_LOOP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_r      <= '0;
      a_r       <= '0;
      b_r       <= '0;
      acc       <= '0;
      cnt       <= '0;
      flag_cf   <= 1'b0;
      flag_zf   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_cf    <= 1'b0;
      rsp_zf    <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          op_r  <= cmd_op;
          a_r   <= cmd_a;
          b_r   <= cmd_b;
          acc   <= '0;
          cnt   <= '0;
          state <= (cmd_op == OP_MUL) ? MUL_LOOP : EXEC;
        end
        EXEC: begin
          if (dec_ill) begin
            rsp_data <= '0;
            rsp_cf   <= 1'b0;
            rsp_zf   <= 1'b0;
            rsp_err  <= 1'b1;
          end else begin
            rsp_data <= alu_o;
            rsp_cf   <= alu_cf;
            rsp_zf   <= alu_zf;
            rsp_err  <= 1'b0;
            flag_cf  <= alu_cf;
            flag_zf  <= alu_zf;
          end
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        MUL_LOOP: begin
          acc <= mul_next;
          a_r <= a_r << 1;
          cnt <= cnt + 4'd1;
          if (cnt == 4'(MUL_ITERS - 1)) begin
            rsp_data  <= mul_next;
            rsp_cf    <= 1'b0;
            rsp_zf    <= (mul_next == '0);
            rsp_err   <= 1'b0;
            flag_cf   <= 1'b0;
            flag_zf   <= (mul_next == '0);
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural combinational ALU attached.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [3:0]  cmd_op = '0;
  logic [15:0] cmd_a = '0, cmd_b = '0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic        rsp_cf, rsp_zf, rsp_err;
  logic [15:0] alu_a, alu_b, alu_o;
  logic        alu_ci, alu_nb, alu_ic, alu_na, alu_xo, alu_no, alu_rot;
  logic        alu_cf, alu_zf;

  int checks = 0, errors = 0;
  int lat;

  always #5 clk = ~clk;

  alu_sequencer #(.W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_cf(rsp_cf), .rsp_zf(rsp_zf), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ci(alu_ci), .alu_nb(alu_nb),
    .alu_ic(alu_ic), .alu_na(alu_na), .alu_xo(alu_xo), .alu_no(alu_no),
    .alu_rot(alu_rot), .alu_o(alu_o), .alu_cf(alu_cf), .alu_zf(alu_zf)
  );

  // ALU: optional operand inversion, add (or carry-inhibited xor/or), output inversion
  logic [15:0] ma, mb, r;
  logic [16:0] s;
  logic        c;
  always_comb begin
    ma = alu_na ? ~alu_a : alu_a;
    mb = alu_nb ? ~alu_b : alu_b;
    s  = 17'(ma) + 17'(mb) + 17'(alu_ci);
    r  = s[15:0];
    c  = s[16];
    if (alu_ic) begin
      r = alu_xo ? (ma | mb) : (ma ^ mb);
      c = 1'b0;
    end
    if (alu_rot) begin
      r = {alu_a[14:0], alu_a[15]};
      c = alu_a[15];
    end
    if (alu_no) r = ~r;
    alu_o  = r;
    alu_cf = c;
    alu_zf = (r == 16'h0);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present a command, wait for accept, then count cycles to rsp_valid.
  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       output int l);
    int guard = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    while (!cmd_ready && guard < 50) begin @(negedge clk); guard++; end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    l = 1;
    while (!rsp_valid && l < 40) begin @(negedge clk); l++; end
  endtask

  task automatic release_rsp(input string tag);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk(tag, 32'(cmd_ready), 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(cmd_ready), 1);
    chk("rst_valid", 32'(rsp_valid), 0);
    chk("rst_data",  32'(rsp_data), 0);
    chk("rst_alu_a", 32'(alu_a), 0);
    rst_n = 1'b1;

    issue(4'd1, 16'h0005, 16'h0005, lat);
    chk("sub_lat", lat, 2);
    chk("sub_data", 32'(rsp_data), 0);
    chk("sub_zf", 32'(rsp_zf), 1);
    chk("sub_cf", 32'(rsp_cf), 1);
    chk("sub_err", 32'(rsp_err), 0);
    release_rsp("sub_rdy");

    issue(4'd0, 16'hFFFF, 16'h0001, lat);
    chk("add_data", 32'(rsp_data), 0);
    chk("add_cf", 32'(rsp_cf), 1);
    release_rsp("add_rdy");
    issue(4'd6, 16'h0000, 16'h0000, lat);
    chk("adc_data", 32'(rsp_data), 'h0001);
    chk("adc_cf", 32'(rsp_cf), 0);
    chk("adc_zf", 32'(rsp_zf), 0);
    release_rsp("adc_rdy");

    issue(4'd2, 16'hF0F0, 16'h3C3C, lat);
    chk("and_data", 32'(rsp_data), 'h3030);
    release_rsp("and_rdy");
    issue(4'd3, 16'hF0F0, 16'h3C3C, lat);
    chk("or_data", 32'(rsp_data), 'hFCFC);
    release_rsp("or_rdy");
    issue(4'd4, 16'hF0F0, 16'h3C3C, lat);
    chk("xor_data", 32'(rsp_data), 'hCCCC);
    chk("xor_lat", lat, 2);
    release_rsp("xor_rdy");

    issue(4'd7, 16'h0123, 16'h0010, lat);
    chk("mul1_lat", lat, 17);
    chk("mul1_data", 32'(rsp_data), 'h1230);
    chk("mul1_cf", 32'(rsp_cf), 0);
    chk("mul1_zf", 32'(rsp_zf), 0);
    release_rsp("mul1_rdy");
    issue(4'd7, 16'h8000, 16'h0002, lat);
    chk("mul2_data", 32'(rsp_data), 0);
    chk("mul2_zf", 32'(rsp_zf), 1);
    release_rsp("mul2_rdy");

    // Set carry, then an illegal op must leave it intact for the next ADC
    issue(4'd0, 16'hFFFF, 16'h0001, lat);
    release_rsp("add2_rdy");
    issue(4'hA, 16'h1234, 16'h5678, lat);
    chk("ill_lat", lat, 2);
    chk("ill_err", 32'(rsp_err), 1);
    chk("ill_data", 32'(rsp_data), 0);
    cmd_valid = 1'b1; cmd_op = 4'd0; cmd_a = 16'h0001; cmd_b = 16'h0001;
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 32'(rsp_valid), 1);
      chk("hold_data", 32'(rsp_data), 0);
      chk("hold_err", 32'(rsp_err), 1);
      chk("hold_ready", 32'(cmd_ready), 0);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    release_rsp("ill_rdy");
    repeat (3) begin
      @(negedge clk);
      chk("not_queued", 32'(rsp_valid), 0);
    end
    issue(4'd6, 16'h0000, 16'h0000, lat);
    chk("adc2_data", 32'(rsp_data), 'h0001);
    release_rsp("adc2_rdy");

    // Reset during MUL iteration 8 discards the operation
    issue(4'd7, 16'h0123, 16'h0010, lat);
    chk("mul3_lat", lat, 17);
    release_rsp("mul3_rdy");
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 4'd7; cmd_a = 16'h0123; cmd_b = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("mid_mul_ready", 32'(cmd_ready), 0);
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", 32'(rsp_valid), 0);
    chk("mrst_ready", 32'(cmd_ready), 1);
    chk("mrst_alu_a", 32'(alu_a), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) chk("mrst_no_rsp", 32'(rsp_valid), 0);
    end
    chk("mrst_quiet", 32'(rsp_valid), 0);
    issue(4'd6, 16'h0000, 16'h0000, lat);
    chk("adc3_data", 32'(rsp_data), 0);
    chk("adc3_zf", 32'(rsp_zf), 1);
    release_rsp("adc3_rdy");
    issue(4'd0, 16'h0002, 16'h0003, lat);
    chk("add3_lat", lat, 2);
    chk("add3_data", 32'(rsp_data), 'h0005);
    release_rsp("add3_rdy");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
